// File: rtl/vga_fb_writer.sv
// vga_fb_writer: queues CPU screen writes and drains them (or a full clear) into the framebuffer
module vga_fb_writer #(
  parameter logic [15:0] BASE_ADDR   = 16'h0200,
  parameter logic [15:0] CLEAR_ADDR  = 16'hFD00,
  parameter int          FIFO_DEPTH  = 4,
  parameter bit          VBLANK_ONLY = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  input  logic        cpu_we,
  output logic        cpu_ready,
  input  logic        vblank,
  output logic        fb_write_en,
  output logic [9:0]  fb_waddr,
  output logic [3:0]  fb_din,
  output logic        busy,
  output logic        overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, state_nx;
  logic [13:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  logic [9:0] clear_ptr;
  logic [3:0] clear_colour;
  logic [15:0] offs;
  logic drain_ok, in_window, is_clear, push, pop, start_clear, clear_wr, last, dropped;
  logic unused;
  assign unused = ^cpu_din[7:4];
  assign offs = cpu_addr - BASE_ADDR;
  assign drain_ok = !VBLANK_ONLY || vblank;
  assign in_window = offs < 16'd1024;
  assign is_clear = cpu_addr == CLEAR_ADDR;
  assign cpu_ready = !reset && state == IDLE && count != FIFO_DEPTH[AW:0];
  assign push = cpu_we && cpu_ready && in_window;
  assign start_clear = cpu_we && cpu_ready && is_clear;
  // a clear supersedes anything still queued, so nothing is popped on its trigger edge
  assign pop = state == IDLE && count != '0 && drain_ok && !start_clear;
  assign clear_wr = state == CLEAR && drain_ok;
  assign last = clear_wr && clear_ptr == 10'd1023;
  assign dropped = cpu_we && !cpu_ready && (in_window || is_clear);
  // next state: enter CLEAR on the trigger write, leave after address 1023 is written
  always_comb begin
    state_nx = start_clear ? CLEAR : last ? IDLE : state;
  end
  // queue storage needs no reset; validity is tracked by count
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {offs[9:0], cpu_din[3:0]};
  end
  // state, queue pointers, clear sequencer and registered RAM port
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      clear_ptr    <= '0;
      clear_colour <= '0;
      fb_write_en  <= 1'b0;
      fb_waddr     <= '0;
      fb_din       <= '0;
      busy         <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      state        <= state_nx;
      fb_write_en  <= pop || clear_wr;
      overflow     <= overflow || dropped;
      busy         <= start_clear || (busy && !last);
      clear_ptr    <= start_clear ? 10'd0 : clear_wr ? clear_ptr + 10'd1 : clear_ptr;
      clear_colour <= start_clear ? cpu_din[3:0] : clear_colour;
      if (pop) {fb_waddr, fb_din} <= mem[rd_ptr];
      else if (clear_wr) {fb_waddr, fb_din} <= {clear_ptr, clear_colour};
      if (start_clear) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
        wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
        count  <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      end
    end
  end
endmodule

// File: doc/vga_fb_writer.md
Name: vga_fb_writer

Overview:
CPU-side writer for the 32x32 video framebuffer. The VGA output path reads this framebuffer, one 4-bit palette index per pixel, pixel address {y[4:0], x[4:0]}. The block accepts 6502 bus writes to screen memory ($0200-$05FF) and queues them in a small FIFO. It drains the queue to the framebuffer RAM write port, optionally only during vertical blanking. It also runs a hardware clear-screen sequence triggered by a control address.

Parameters:
BASE_ADDR, 16'h0200, first CPU address of the 1024-byte screen window
CLEAR_ADDR, 16'hFD00, CPU address whose write starts a full-screen clear
FIFO_DEPTH, 4, write queue depth; power of two, at least 2
VBLANK_ONLY, 0, 1 = framebuffer writes issued only while vblank=1

Ports:
clk  in  1  system clock, same as the VGA pixel clock
reset  in  1  synchronous, active-high
cpu_addr  in  16  CPU bus address
cpu_din  in  8  CPU write data; only bits [3:0] are stored
cpu_we  in  1  CPU write strobe, one cycle per write
cpu_ready  out  1  write can be accepted this cycle (drives 6502 RDY)
vblank  in  1  high during vertical blanking
fb_write_en  out  1  framebuffer RAM write enable (registered)
fb_waddr  out  10  framebuffer RAM write address (registered)
fb_din  out  4  framebuffer RAM write data (registered)
busy  out  1  clear sequence in progress
overflow  out  1  sticky: a write was dropped

Behaviour:
- Reset values: fb_write_en=0, fb_waddr=0, fb_din=0, busy=0, overflow=0. FIFO is empty and state is IDLE. cpu_ready=0 while reset is high.
- cpu_ready (combinational) = !reset && state==IDLE && FIFO not full.
- in_window = (cpu_addr - BASE_ADDR) < 1024, computed as a 16-bit unsigned compare.
- Push: cpu_we && cpu_ready && in_window pushes {cpu_addr-BASE_ADDR [9:0], cpu_din[3:0]}.
- Dropped writes: cpu_we && !cpu_ready, with in_window or addr==CLEAR_ADDR, is dropped and sets overflow at the next edge. overflow clears only on reset.
- Writes to any other address are ignored, with no state change.
- Pop: in IDLE, if the FIFO is non-empty and (VBLANK_ONLY==0 || vblank), one entry is popped per cycle. At the same edge, fb_write_en=1 and fb_waddr/fb_din are set to that entry. Otherwise fb_write_en=0 at that edge.
- Latency: a write pushed at edge N appears on the fb_* outputs after edge N+1 when the FIFO was empty and the drain condition holds.
- Order: FIFO order is preserved. Simultaneous push and pop leaves the count unchanged. The full flag uses a count with log2(FIFO_DEPTH)+1 bits.
- Repeated writes to the same address are not coalesced; each write reaches the RAM.
- States: IDLE and CLEAR.
- IDLE to CLEAR: cpu_we && cpu_ready && cpu_addr==CLEAR_ADDR. This latches clear_colour=cpu_din[3:0], discards all FIFO contents (they are superseded), sets clear_ptr=0 and busy=1.
- CLEAR: each cycle in which (VBLANK_ONLY==0 || vblank) holds, the block issues fb_write_en=1, fb_waddr=clear_ptr, fb_din=clear_colour, then increments clear_ptr. Otherwise it holds clear_ptr with fb_write_en=0.
- CLEAR to IDLE: after the write of address 1023 issues, at that same edge busy goes to 0. Total is exactly 1024 write cycles.
- cpu_ready=0 throughout CLEAR. Screen and clear writes during CLEAR count as dropped.
- Reset mid-operation: at the reset edge the state returns to IDLE, the FIFO is emptied, fb_write_en=0 and busy=0. A partial clear is not resumed.
- clear_ptr is 10 bits. Its wrap from 1023 to 0 coincides with the exit from CLEAR and never produces a duplicate write.

Test Plan:
- Single write, VBLANK_ONLY=0: write $0200 with data 8'h05 -> one cycle later fb_write_en=1, fb_waddr=0, fb_din=5, for exactly one cycle.
- Upper bound and data masking: write $05FF with 8'hF3 -> fb_waddr=1023, fb_din=3. Writes to $0600, $01FF and $FE00 -> no fb_write_en and overflow stays 0.
- Backpressure, VBLANK_ONLY=1, vblank=0: 5 back-to-back writes to $0200-$0204 (data 1-5) -> cpu_ready drops after the 4th and the 5th is dropped, setting overflow=1. Raising vblank -> addresses 0,1,2,3 with data 1,2,3,4 on 4 consecutive cycles, then cpu_ready=1.
- Clear: write $FD00 with 8'h02 while 2 entries are queued -> queued entries never written. busy=1 for 1024 cycles with fb_waddr stepping 0..1023, all fb_din=2, then busy=0 and cpu_ready=1.
- Clear gated: VBLANK_ONLY=1, toggle vblank mid-clear -> writes pause with the address held and resume contiguously. The total is still 1024 distinct addresses.
- Reset mid-clear at fb_waddr=300 -> after the reset edge fb_write_en=0, busy=0, overflow=0. A following write to $0201 produces fb_waddr=1.
